// File: rtl/byte_ram_pkg.sv
// Shared definitions for byte_ram: byte-offset derivation, FSM encoding and legal parameter ranges.
// INIT is only reachable when BYTE_RAM_INIT_CLEAR_EN is defined.
package byte_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 4;
    localparam int MIN_DATA_WIDTH   = 8;
    localparam int MAX_DATA_WIDTH   = 128;

    function automatic int calcOfs(input int dataWidth);
        return $clog2(dataWidth / 8);
    endfunction

    function automatic bit widthLegal(input int dataWidth);
        return (dataWidth >= MIN_DATA_WIDTH) && (dataWidth <= MAX_DATA_WIDTH) &&
               ((dataWidth & (dataWidth - 1)) == 0);
    endfunction

    function automatic bit latencyLegal(input int latency);
        return (latency >= MIN_READ_LATENCY) && (latency <= MAX_READ_LATENCY);
    endfunction

endpackage

// File: rtl/byte_ram_rdpipe.sv
// LATENCY-stage valid/data/err shift register carrying read responses out of byte_ram.
// Data and err only load when the stage is valid, so idle stages always hold zero.
module byte_ram_rdpipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  err_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  err_o
);

    logic [LATENCY-1:0]    valid_q;
    logic [LATENCY-1:0]    err_q;
    logic [DATA_WIDTH-1:0] data_q [LATENCY];

    // Reset drops every in-flight response so nothing escapes after rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            err_q[0]   <= valid_i & err_i;
            data_q[0]  <= valid_i ? data_i : '0;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign err_o   = err_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/byte_ram.sv
// Single-port word RAM with byte-addressed requests, byte enables and a registered read pipeline.
// Define BYTE_RAM_INIT_CLEAR_EN to zero the whole array after every reset before accepting requests.
module byte_ram
    import byte_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic                    err_pulse
);

    localparam int OFS    = calcOfs(DATA_WIDTH);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int WIDX_W = ADDR_WIDTH - OFS;
    localparam int DEPTH  = 1 << WIDX_W;
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'((1 << OFS) - 1);

    generate
        if (!widthLegal(DATA_WIDTH)) begin : g_bad_width
            $error("byte_ram: illegal DATA_WIDTH %0d", DATA_WIDTH);
        end
        if (!latencyLegal(READ_LATENCY)) begin : g_bad_latency
            $error("byte_ram: illegal READ_LATENCY %0d", READ_LATENCY);
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e      state_q;
    logic        ready_q;
    logic        errPulse_q;
`ifdef BYTE_RAM_INIT_CLEAR_EN
    logic [WIDX_W-1:0] clrIdx_q;
`endif

    logic              accept;
    logic              misaligned;
    logic              wrCommit;
    logic              rdIssue;
    logic [WIDX_W-1:0] wordIdx;
    logic [DATA_WIDTH-1:0] rdData;

    assign accept     = req_valid & ready_q;
    assign misaligned = |(req_addr & OFS_MASK);
    assign wordIdx    = req_addr[ADDR_WIDTH-1:OFS];
    assign wrCommit   = accept & req_we & ~misaligned;
    assign rdIssue    = accept & ~req_we;
    assign rdData     = misaligned ? '0 : mem[wordIdx];

    // Ready only rises on the edge after RUN is reached, so the first accept is one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef BYTE_RAM_INIT_CLEAR_EN
            state_q  <= INIT;
            clrIdx_q <= '0;
`else
            state_q  <= RUN;
`endif
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
`ifdef BYTE_RAM_INIT_CLEAR_EN
                INIT: begin
                    ready_q  <= 1'b0;
                    clrIdx_q <= clrIdx_q + WIDX_W'(1);
                    if (clrIdx_q == WIDX_W'(DEPTH - 1)) begin
                        state_q <= RUN;
                    end
                end
`endif
                RUN:     ready_q <= 1'b1;
                default: state_q <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errPulse_q <= 1'b0;
        end else begin
            errPulse_q <= accept & req_we & misaligned;
        end
    end

    // Storage has no reset; a read issued right after a write sees the updated word.
    always_ff @(posedge clk) begin
        if (wrCommit) begin
            for (int i = 0; i < BYTES; i++) begin
                if (req_be[i]) begin
                    mem[wordIdx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
`ifdef BYTE_RAM_INIT_CLEAR_EN
        if (state_q == INIT) begin
            mem[clrIdx_q] <= '0;
        end
`endif
    end

    byte_ram_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_rdpipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rdIssue),
        .data_i  (rdData),
        .err_i   (misaligned),
        .valid_o (rsp_valid),
        .data_o  (rsp_data),
        .err_o   (rsp_err)
    );

    assign req_ready = ready_q;
    assign err_pulse = errPulse_q;

endmodule

// File: tb/tb_byte_ram.sv
// Directed bench for byte_ram: two instances (read latency 3 and 4) share one request stream.
// Handles both the default build and BYTE_RAM_INIT_CLEAR_EN.
module tb_byte_ram;

    localparam int DW = 32;
    localparam int AW = 6;
`ifdef BYTE_RAM_INIT_CLEAR_EN
    localparam int READY_DELAY = 17;
`else
    localparam int READY_DELAY = 1;
`endif

    logic          clk;
    logic          rst;
    logic          reqValid;
    logic          reqWe;
    logic [3:0]    reqBe;
    logic [AW-1:0] reqAddr;
    logic [DW-1:0] reqWdata;

    logic          reqReady3, rspValid3, rspErr3, errPulse3;
    logic [DW-1:0] rspData3;
    logic          reqReady4, rspValid4, rspErr4, errPulse4;
    logic [DW-1:0] rspData4;

    int testsRun    = 0;
    int testsFailed = 0;
    logic sawValid;

    byte_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady3), .req_we(reqWe),
        .req_be(reqBe), .req_addr(reqAddr), .req_wdata(reqWdata), .rsp_valid(rspValid3),
        .rsp_data(rspData3), .rsp_err(rspErr3), .err_pulse(errPulse3)
    );

    byte_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady4), .req_we(reqWe),
        .req_be(reqBe), .req_addr(reqAddr), .req_wdata(reqWdata), .rsp_valid(rspValid4),
        .rsp_data(rspData4), .rsp_err(rspErr4), .err_pulse(errPulse4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [3:0] be,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        reqValid = v;
        reqWe    = we;
        reqBe    = be;
        reqAddr  = addr;
        reqWdata = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic writeWord(input logic [AW-1:0] addr, input logic [3:0] be, input logic [DW-1:0] data);
        applyStimulus(1'b1, 1'b1, be, addr, data);
        cycle();
        applyStimulus(1'b0, 1'b0, 4'h0, '0, '0);
    endtask

    // One isolated read, then watch both instances for five cycles starting the cycle after accept.
    task automatic readCheck(input string tag, input logic [AW-1:0] addr,
                             input logic [DW-1:0] expData, input logic expErr);
        applyStimulus(1'b1, 1'b0, 4'h0, addr, '0);
        cycle();
        applyStimulus(1'b0, 1'b0, 4'h0, '0, '0);
        for (int k = 1; k <= 5; k++) begin
            checkOutput({tag, "_valid3"}, rspValid3, k == 3);
            checkOutput({tag, "_data3"},  rspData3, (k == 3) ? expData : '0);
            checkOutput({tag, "_err3"},   rspErr3, (k == 3) ? expErr : 1'b0);
            checkOutput({tag, "_valid4"}, rspValid4, k == 4);
            checkOutput({tag, "_data4"},  rspData4, (k == 4) ? expData : '0);
            checkOutput({tag, "_err4"},   rspErr4, (k == 4) ? expErr : 1'b0);
            cycle();
        end
    endtask

    task automatic waitReady(input string tag);
        int n = 0;
        while (!reqReady3 && n < 100) begin
            cycle();
            n++;
            sawValid = sawValid | rspValid3 | rspValid4;
        end
        checkOutput({tag, "_delay"}, 64'(n), 64'(READY_DELAY));
        checkOutput({tag, "_ready4"}, reqReady4, 1'b1);
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_ready3"}, reqReady3, 1'b0);
        checkOutput({tag, "_ready4"}, reqReady4, 1'b0);
        checkOutput({tag, "_valid3"}, rspValid3, 1'b0);
        checkOutput({tag, "_valid4"}, rspValid4, 1'b0);
        checkOutput({tag, "_data3"},  rspData3, '0);
        checkOutput({tag, "_data4"},  rspData4, '0);
        checkOutput({tag, "_err3"},   rspErr3, 1'b0);
        checkOutput({tag, "_errp3"},  errPulse3, 1'b0);
        checkOutput({tag, "_errp4"},  errPulse4, 1'b0);
    endtask

    logic [DW-1:0] b2bData [3];

    initial begin
        b2bData[0] = 32'h1111_1111;
        b2bData[1] = 32'h2222_2222;
        b2bData[2] = 32'h3333_3333;
        sawValid   = 1'b0;
        rst        = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, '0, '0);
        repeat (3) cycle();
        checkIdleZero("reset");

        rst = 1'b0;
        waitReady("rdy_first");

`ifdef BYTE_RAM_INIT_CLEAR_EN
        readCheck("init_zero", 6'h0C, 32'h0, 1'b0);
`endif

        // Byte-enable merge, with the read issued right behind the second write.
        applyStimulus(1'b1, 1'b1, 4'b1111, 6'h08, 32'hDEAD_BEEF);
        cycle();
        applyStimulus(1'b1, 1'b1, 4'b0001, 6'h08, 32'h0000_00AA);
        cycle();
        readCheck("merge", 6'h08, 32'hDEAD_BEAA, 1'b0);

        writeWord(6'h08, 4'b0000, 32'hFFFF_FFFF);
        readCheck("be_zero", 6'h08, 32'hDEAD_BEAA, 1'b0);

        for (int i = 0; i < 3; i++) begin
            writeWord(AW'(4 * i), 4'b1111, b2bData[i]);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 4'h0, AW'(4 * i), '0);
            cycle();
        end
        applyStimulus(1'b0, 1'b0, 4'h0, '0, '0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("b2b_valid3", rspValid3, k < 3);
            checkOutput("b2b_data3", rspData3, (k < 3) ? b2bData[k] : '0);
            checkOutput("b2b_valid4", rspValid4, (k >= 1) && (k < 4));
            checkOutput("b2b_data4", rspData4, ((k >= 1) && (k < 4)) ? b2bData[k-1] : '0);
            cycle();
        end

        applyStimulus(1'b1, 1'b1, 4'b1111, 6'h05, 32'hFFFF_FFFF);
        cycle();
        applyStimulus(1'b0, 1'b0, 4'h0, '0, '0);
        checkOutput("mis_wr_pulse3", errPulse3, 1'b1);
        checkOutput("mis_wr_pulse4", errPulse4, 1'b1);
        checkOutput("mis_wr_novalid", rspValid3, 1'b0);
        cycle();
        checkOutput("mis_wr_pulse_end", errPulse3, 1'b0);
        readCheck("mis_wr_keep", 6'h04, 32'h2222_2222, 1'b0);

        readCheck("mis_rd", 6'h06, 32'h0, 1'b1);

        // Two reads in flight when reset hits: neither may come out.
        applyStimulus(1'b1, 1'b0, 4'h0, 6'h00, '0);
        cycle();
        applyStimulus(1'b1, 1'b0, 4'h0, 6'h04, '0);
        cycle();
        applyStimulus(1'b0, 1'b0, 4'h0, '0, '0);
        rst = 1'b1;
        #1;
        checkIdleZero("rst_mid");
        sawValid = 1'b0;
        repeat (2) begin
            cycle();
            sawValid = sawValid | rspValid3 | rspValid4;
        end
        rst = 1'b0;
        waitReady("rdy_rst_mid");
        repeat (6) begin
            cycle();
            sawValid = sawValid | rspValid3 | rspValid4;
        end
        checkOutput("rst_mid_no_resp", sawValid, 1'b0);

`ifdef BYTE_RAM_INIT_CLEAR_EN
        readCheck("after_rst_word", 6'h04, 32'h0, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (7) cycle();
        checkOutput("clr_mid_ready", reqReady3, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        waitReady("rdy_clr_restart");
`else
        readCheck("after_rst_word", 6'h04, 32'h2222_2222, 1'b0);
`endif

        writeWord(6'h3C, 4'b1010, 32'hA5A5_5A5A);
        writeWord(6'h3C, 4'b0101, 32'h1234_5678);
        readCheck("top_word", 6'h3C, 32'hA534_5A78, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
